output_collector: RTL and testbench

//  Downstream of the convolution controller/ODS. Each output_valid beat carries 3 accumulated

---
 rtl/output_collector_pkg.sv | 73 +++++++
 rtl/output_collector_fifo.sv | 74 +++++++
 rtl/output_collector.sv | 236 +++++++++++++++++++++++
 tb/tb_output_collector.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_collector_pkg.sv
// Shared types and helpers for the output collector.
// beat_t is one FIFO entry: the coordinates of a beat, the channel of lane 0,
// a mask of lanes that map to real output channels, and the raw lane values.
package output_collector_pkg;

    localparam int LANES       = 3;
    localparam int ACC_WIDTH   = 32;
    localparam int COORD_WIDTH = 32;

    typedef struct packed {
        logic [COORD_WIDTH-1:0]                x;
        logic [COORD_WIDTH-1:0]                y;
        logic [COORD_WIDTH-1:0]                ch;
        logic [LANES-1:0]                      lane_mask;
        logic [LANES-1:0][ACC_WIDTH-1:0]       data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Clamp a signed accumulator to the signed range of an out_width-bit word.
    // The result is still ACC_WIDTH wide; callers keep the low out_width bits.
    function automatic logic [ACC_WIDTH-1:0] sat_to_out(input logic [ACC_WIDTH-1:0] value,
                                                        input int out_width);
        logic signed [ACC_WIDTH-1:0] v;
        logic signed [ACC_WIDTH-1:0] max_v;
        logic signed [ACC_WIDTH-1:0] min_v;
        v     = signed'(value);
        max_v = signed'((ACC_WIDTH'(1) << (out_width - 1)) - ACC_WIDTH'(1));
        min_v = ~max_v;  // two's complement: -max-1
        if (v > max_v) begin
            return max_v;
        end
        if (v < min_v) begin
            return min_v;
        end
        return v;
    endfunction

    // Lowest lane set in the mask (0 when the mask is empty).
    function automatic logic [1:0] first_lane(input logic [LANES-1:0] mask);
        logic [1:0] lane;
        lane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lane = 2'(k);
            end
        end
        return lane;
    endfunction

    // Next valid lane above cur; returns cur itself when none is left.
    function automatic logic [1:0] next_lane(input logic [LANES-1:0] mask,
                                             input logic [1:0]       cur);
        logic [1:0] lane;
        lane = cur;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(cur))) begin
                lane = 2'(k);
            end
        end
        return lane;
    endfunction

    function automatic logic is_last_lane(input logic [LANES-1:0] mask,
                                          input logic [1:0]       cur);
        return next_lane(mask, cur) == cur;
    endfunction

endpackage

// File: rtl/output_collector_fifo.sv
// sync_fifo: single-clock FIFO of beat entries.
// Ports:
//   clk, arst_n_in        clock and synchronous active-low reset
//   push_i, wr_data_i     write request and entry; taken when not full, or when
//                         full and the head is popped in the same cycle
//   pop_i                 retire the head entry
//   head_o                entry at the read pointer
//   next_o                entry behind the head (meaningful when count_o >= 2)
//   full_o, empty_o       occupancy flags
//   count_o               number of stored entries
//   almost_full_o         count_o >= DEPTH-2
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] next_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic             almost_full_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CW'(DEPTH - 2));

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle:
    // the write lands in the slot being freed.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign head_o = mem[rd_ptr_q];
    assign next_o = mem[rd_ptr_q + AW'(1)];

endmodule

// File: rtl/output_collector.sv
// output_collector: buffers 3-lane accumulator beats, saturates each valid lane
// to a signed OUT_WIDTH word and hands the words to the host one per
// valid/ready handshake, pulsing frame_done after the last word of a frame.
// Ports:
//   clk, arst_n_in                 clock and synchronous active-low reset
//   output_valid/_x/_y/_ch         beat strobe, coordinates and lane-0 channel
//   ods_data                       lane k in bits [k*ACC_WIDTH +: ACC_WIDTH]
//   almost_full                    FIFO holds >= FIFO_DEPTH-2 beats
//   overflow                       sticky: a beat was dropped on a full FIFO
//   host_valid/ready/data/x/y/ch   registered host word stream
//   frame_done                     one-cycle pulse after the frame's last word
module output_collector
    import output_collector_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int OUT_WIDTH          = 16,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                       clk,
    input  logic                       arst_n_in,
    input  logic                       output_valid,
    input  logic [31:0]                output_x,
    input  logic [31:0]                output_y,
    input  logic [31:0]                output_ch,
    input  logic [LANES*ACC_WIDTH-1:0] ods_data,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       host_valid,
    input  logic                       host_ready,
    output logic [OUT_WIDTH-1:0]       host_data,
    output logic [31:0]                host_x,
    output logic [31:0]                host_y,
    output logic [31:0]                host_ch,
    output logic                       frame_done
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] FRAME_WORDS =
        32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    beat_t         in_beat;
    beat_t         head_beat;
    beat_t         next_beat;
    beat_t         pop_src;
    beat_t         load_beat;
    logic          push_req;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic [CW-1:0] fifo_count;

    state_t                state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           word_cnt_q, word_cnt_d;
    logic                  mid_frame_q, mid_frame_d;
    logic                  host_valid_q, host_valid_d;
    logic [OUT_WIDTH-1:0]  host_data_q, host_data_d;
    logic [31:0]           host_x_q, host_x_d;
    logic [31:0]           host_y_q, host_y_d;
    logic [31:0]           host_ch_q, host_ch_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  load_en;
    logic [1:0]            load_lane;
    logic [1:0]            nxt_lane;
    logic                  frame_end;

    function automatic logic [OUT_WIDTH-1:0] lane_word(input beat_t b, input logic [1:0] lane);
        logic [ACC_WIDTH-1:0] sat;
        sat = sat_to_out(b.data[lane], OUT_WIDTH);
        return sat[OUT_WIDTH-1:0];
    endfunction

    // Lane mask is frozen at push time; 33-bit sum avoids wrap on huge channels.
    always_comb begin
        in_beat.x         = output_x;
        in_beat.y         = output_y;
        in_beat.ch        = output_ch;
        in_beat.data      = ods_data;
        in_beat.lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            in_beat.lane_mask[k] = (({1'b0, output_ch} + 33'(k)) < 33'(OUTPUT_NB_CHANNELS));
        end
    end

    // A beat with no valid lane would produce no words; it is not stored.
    assign push_req   = output_valid && (in_beat.lane_mask != '0);
    assign overflow_d = overflow_q | (push_req && fifo_full && !fifo_pop);

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .push_i        (push_req),
        .wr_data_i     (in_beat),
        .pop_i         (fifo_pop),
        .head_o        (head_beat),
        .next_o        (next_beat),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .count_o       (fifo_count),
        .almost_full_o (fifo_almost_full)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        word_cnt_d   = word_cnt_q;
        mid_frame_d  = mid_frame_q;
        host_valid_d = host_valid_q;
        host_data_d  = host_data_q;
        host_x_d     = host_x_q;
        host_y_d     = host_y_q;
        host_ch_d    = host_ch_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;
        load_en      = 1'b0;
        load_beat    = head_beat;
        load_lane    = lane_q;
        nxt_lane     = next_lane(head_beat.lane_mask, lane_q);
        frame_end    = (word_cnt_q == FRAME_WORDS - 32'd1);
        // After popping the head, the following word comes from the second
        // entry, or straight from a beat being pushed into an otherwise empty FIFO.
        pop_src      = (fifo_count > CW'(1)) ? next_beat : in_beat;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_en   = 1'b1;
                    load_lane = first_lane(head_beat.lane_mask);
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (host_ready) begin
                    word_cnt_d = word_cnt_q + 32'd1;
                    if (is_last_lane(head_beat.lane_mask, lane_q)) begin
                        fifo_pop = 1'b1;
                        if (frame_end) begin
                            state_d      = ST_DONE;
                            mid_frame_d  = 1'b0;
                            host_valid_d = 1'b0;
                            frame_done_d = 1'b1;
                        end else if ((fifo_count > CW'(1)) || push_req) begin
                            load_en   = 1'b1;
                            load_beat = pop_src;
                            load_lane = first_lane(pop_src.lane_mask);
                        end else begin
                            state_d      = ST_IDLE;
                            host_valid_d = 1'b0;
                        end
                    end else if (frame_end) begin
                        // Frame ended inside a beat: remember where to resume.
                        state_d      = ST_DONE;
                        mid_frame_d  = 1'b1;
                        lane_d       = nxt_lane;
                        host_valid_d = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        load_en   = 1'b1;
                        load_lane = nxt_lane;
                    end
                end
            end
            ST_DONE: begin
                word_cnt_d  = '0;
                mid_frame_d = 1'b0;
                if (mid_frame_q) begin
                    load_en = 1'b1;
                    state_d = ST_EMIT;
                end else if (!fifo_empty) begin
                    load_en   = 1'b1;
                    load_lane = first_lane(head_beat.lane_mask);
                    state_d   = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_en) begin
            lane_d       = load_lane;
            host_valid_d = 1'b1;
            host_data_d  = lane_word(load_beat, load_lane);
            host_x_d     = load_beat.x;
            host_y_d     = load_beat.y;
            host_ch_d    = load_beat.ch + 32'(load_lane);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            word_cnt_q   <= '0;
            mid_frame_q  <= 1'b0;
            host_valid_q <= 1'b0;
            host_data_q  <= '0;
            host_x_q     <= '0;
            host_y_q     <= '0;
            host_ch_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_cnt_q   <= word_cnt_d;
            mid_frame_q  <= mid_frame_d;
            host_valid_q <= host_valid_d;
            host_data_q  <= host_data_d;
            host_x_q     <= host_x_d;
            host_y_q     <= host_y_d;
            host_ch_q    <= host_ch_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign almost_full = fifo_almost_full;
    assign overflow    = overflow_q;
    assign host_valid  = host_valid_q;
    assign host_data   = host_data_q;
    assign host_x      = host_x_q;
    assign host_y      = host_y_q;
    assign host_ch     = host_ch_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector on a 4x4 map with 6 output channels, so a full
// frame is 96 words and the channel-drop boundary sits at channel 6.
module tb_output_collector;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int C     = 6;
    localparam int OW    = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = W * H * C;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          output_valid;
    logic [31:0]   output_x;
    logic [31:0]   output_y;
    logic [31:0]   output_ch;
    logic [95:0]   ods_data;
    logic          almost_full;
    logic          overflow;
    logic          host_valid;
    logic          host_ready;
    logic [OW-1:0] host_data;
    logic [31:0]   host_x;
    logic [31:0]   host_y;
    logic [31:0]   host_ch;
    logic          frame_done;

    always #5 clk = ~clk;

    output_collector #(
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .OUTPUT_NB_CHANNELS (C),
        .OUT_WIDTH          (OW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .clk          (clk),
        .arst_n_in    (arst_n_in),
        .output_valid (output_valid),
        .output_x     (output_x),
        .output_y     (output_y),
        .output_ch    (output_ch),
        .ods_data     (ods_data),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_data    (host_data),
        .host_x       (host_x),
        .host_y       (host_y),
        .host_ch      (host_ch),
        .frame_done   (frame_done)
    );

    // Reference model: a queue of expected host words in delivery order, plus
    // the number of beats still holding undelivered words.
    typedef struct {
        logic [15:0] data;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
        bit          last;
    } word_t;

    word_t expq[$];
    int    occ;
    int    words_done;
    int    hs_count;
    int    done_seen;
    bit    exp_ovf;
    bit    exp_done;
    int    checks;
    int    errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [31:0] v);
        int s;
        s = int'(signed'(v));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    function automatic logic [31:0] rnd_acc();
        if ($urandom_range(0, 1) == 1) return $urandom();
        return 32'($urandom_range(0, 80000)) - 32'd40000;
    endfunction

    task automatic do_reset();
        arst_n_in    = 1'b0;
        output_valid = 1'b0;
        host_ready   = 1'b0;
        @(posedge clk);
        #1;
        arst_n_in  = 1'b1;
        expq.delete();
        occ        = 0;
        exp_ovf    = 1'b0;
        exp_done   = 1'b0;
        words_done = 0;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance
    // the model to what the next rising edge should produce.
    task automatic step(input bit v, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ch, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2, input bit rdy);
        bit          hs;
        bit          pop_last;
        int          nvalid;
        word_t       w;
        logic [31:0] d[3];
        output_valid = v;
        output_x     = x;
        output_y     = y;
        output_ch    = ch;
        ods_data     = {d2, d1, d0};
        host_ready   = rdy;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        @(negedge clk);
        check("almost_full", 32'(almost_full), 32'(occ >= DEPTH - 2));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("frame_done", 32'(frame_done), 32'(exp_done));
        if (frame_done) done_seen++;
        if (expq.size() == 0) check("idle_valid", 32'(host_valid), 32'd0);
        hs       = host_valid && rdy;
        pop_last = 1'b0;
        exp_done = 1'b0;
        if (hs) begin
            hs_count++;
            check("word_available", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                w = expq.pop_front();
                check("host_data", 32'(host_data), 32'(w.data));
                check("host_x", host_x, w.x);
                check("host_y", host_y, w.y);
                check("host_ch", host_ch, w.ch);
                pop_last = w.last;
            end
            words_done++;
            if (words_done == FRAME) begin
                exp_done   = 1'b1;
                words_done = 0;
            end
        end
        nvalid = 0;
        for (int k = 0; k < 3; k++) begin
            if (longint'(ch) + k < C) nvalid++;
        end
        if (v && nvalid > 0) begin
            if (occ < DEPTH || pop_last) begin
                for (int k = 0; k < nvalid; k++) begin
                    w.data = sat16(d[k]);
                    w.x    = x;
                    w.y    = y;
                    w.ch   = ch + 32'(k);
                    w.last = (k == nvalid - 1);
                    expq.push_back(w);
                end
                occ++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (pop_last) occ--;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic push_rnd(input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] ch, input bit rdy);
        step(1'b1, x, y, ch, rnd_acc(), rnd_acc(), rnd_acc(), rdy);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expq.size() > 0; i++) idle(1'b1);
        check("drain_complete", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int hs0;
        int bi;
        checks       = 0;
        errors       = 0;
        hs_count     = 0;
        done_seen    = 0;
        arst_n_in    = 1'b0;
        output_valid = 1'b0;
        output_x     = '0;
        output_y     = '0;
        output_ch    = '0;
        ods_data     = '0;
        host_ready   = 1'b0;

        // Reset state
        do_reset();
        check("rst_host_valid", 32'(host_valid), 32'd0);
        check("rst_host_data", 32'(host_data), 32'd0);
        check("rst_host_x", host_x, 32'd0);
        check("rst_host_y", host_y, 32'd0);
        check("rst_host_ch", host_ch, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // 1: single beat, saturation, first-word latency
        step(1'b1, 32'd1, 32'd2, 32'd0, 32'd5, 32'hFFFF_FFF9, 32'd100000, 1'b1);
        check("t1_valid_at_push_edge", 32'(host_valid), 32'd0);
        idle(1'b1);
        check("t1_valid_next_edge", 32'(host_valid), 32'd1);
        check("t1_word0", 32'(host_data), 32'h0005);
        check("t1_ch0", host_ch, 32'd0);
        idle(1'b1);
        check("t1_word1", 32'(host_data), 32'hFFF9);
        idle(1'b1);
        check("t1_word2", 32'(host_data), 32'h7FFF);
        check("t1_ch2", host_ch, 32'd2);
        idle(1'b1);
        check("t1_back_idle", 32'(host_valid), 32'd0);
        $display("t1 single beat: checks=%0d errors=%0d", checks, errors);

        // 2: lanes above the last channel are dropped
        hs0 = hs_count;
        push_rnd(32'd3, 32'd1, 32'd4, 1'b1);
        drain(20);
        check("t2_ch4_words", 32'(hs_count - hs0), 32'd2);
        hs0 = hs_count;
        push_rnd(32'd2, 32'd3, 32'd5, 1'b1);
        drain(20);
        check("t2_ch5_words", 32'(hs_count - hs0), 32'd1);
        idle(1'b1);
        check("t2_idle_after", 32'(host_valid), 32'd0);
        $display("t2 lane mask: checks=%0d errors=%0d", checks, errors);

        // 3: fill with host stalled, drops and sticky overflow, ordered drain
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push_rnd(32'(i), 32'd0, 32'd0, 1'b0);
            if (i == 4) check("t3_af_count5", 32'(almost_full), 32'd0);
            if (i == 5) check("t3_af_count6", 32'(almost_full), 32'd1);
        end
        check("t3_overflow_set", 32'(overflow), 32'd1);
        hs0 = hs_count;
        drain(100);
        check("t3_words", 32'(hs_count - hs0), 32'd24);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        $display("t3 overflow: checks=%0d errors=%0d", checks, errors);

        // 4: push into a full FIFO while the head retires
        do_reset();
        for (int i = 0; i < 8; i++) push_rnd(32'(i), 32'd1, 32'd4, 1'b0);
        check("t4_full_af", 32'(almost_full), 32'd1);
        idle(1'b1);
        push_rnd(32'd9, 32'd1, 32'd4, 1'b1);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        push_rnd(32'd10, 32'd1, 32'd4, 1'b0);
        check("t4_still_full", 32'(overflow), 32'd1);
        $display("t4 full push+pop: checks=%0d errors=%0d", checks, errors);

        // 5: full frame with random host backpressure
        do_reset();
        hs0       = hs_count;
        done_seen = 0;
        bi        = 0;
        for (int i = 0; i < 3000 && (bi < 2 * W * H || expq.size() > 0); i++) begin
            if (bi < 2 * W * H && occ < DEPTH - 2) begin
                push_rnd(32'((bi / 2) % W), 32'((bi / 2) / W), 32'((bi % 2) * 3),
                         1'($urandom_range(0, 1)));
                bi++;
            end else begin
                idle(1'($urandom_range(0, 1)));
            end
        end
        idle(1'b0);
        idle(1'b0);
        check("t5_all_pushed", 32'(bi), 32'(2 * W * H));
        check("t5_queue_empty", 32'(expq.size()), 32'd0);
        check("t5_words", 32'(hs_count - hs0), 32'(FRAME));
        check("t5_frame_done_once", 32'(done_seen), 32'd1);
        $display("t5 full frame: checks=%0d errors=%0d", checks, errors);

        // 6: reset in the middle of a stream
        do_reset();
        for (int i = 0; i < 10; i++) push_rnd(32'(i), 32'd2, 32'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("t6_overflow_before", 32'(overflow), 32'd1);
        do_reset();
        check("t6_valid_after_rst", 32'(host_valid), 32'd0);
        check("t6_overflow_after_rst", 32'(overflow), 32'd0);
        check("t6_af_after_rst", 32'(almost_full), 32'd0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check("t6_stays_empty", 32'(host_valid), 32'd0);
        $display("t6 mid-stream reset: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
